// File: rtl/elixirchip_es1_spu_op_sel_arbiter_if.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_op_sel_arbiter_if
// Request/grant bundle between N requesters and the op_sel arbiter, plus the
// selector control outputs and the beat-ownership tag that trails the selector.
//   s_req     [N]        request per requester (held while its beat is pending)
//   s_last    [N]        current beat is the requester's last (0 keeps the lock)
//   m_ack     [N]        one-hot grant, beat consumed at a clock edge with cke
//   m_sel     [SEL_BITS] granted index, drives the selector's s_sel
//   m_valid              a grant is active, drives the selector's s_valid
//   m_clear              drives the selector's s_clear
//   m_busy               burst lock held
//   out_valid            selector m_data carries a granted beat
//   out_id    [SEL_BITS] owner of that beat
// modport master: requester side; modport slave: arbiter side.
// ---------------------------------------------------------------------------
interface elixirchip_es1_spu_op_sel_arbiter_if #(
    parameter int unsigned N        = 4,
    parameter int unsigned SEL_BITS = $clog2(N)
);
    logic [N-1:0]        s_req;
    logic [N-1:0]        s_last;
    logic [N-1:0]        m_ack;
    logic [SEL_BITS-1:0] m_sel;
    logic                m_valid;
    logic                m_clear;
    logic                m_busy;
    logic                out_valid;
    logic [SEL_BITS-1:0] out_id;

    modport master (
        output s_req, s_last,
        input  m_ack, m_sel, m_valid, m_clear, m_busy, out_valid, out_id
    );

    modport slave (
        input  s_req, s_last,
        output m_ack, m_sel, m_valid, m_clear, m_busy, out_valid, out_id
    );
endinterface

// File: rtl/elixirchip_es1_spu_op_sel_arbiter.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_op_sel_arbiter
// Round-robin arbiter sharing one elixirchip_es1_spu_op_sel between N
// requesters, with s_last-controlled locked bursts and a LATENCY-deep tag
// pipeline that marks which requester owns each selector output beat.
//   reset  synchronous, active-high
//   clk    clock
//   cke    clock enable; all state (grant pointer, lock, tag pipe) holds at 0
//   bus    slave view of elixirchip_es1_spu_op_sel_arbiter_if
// Grant outputs are combinational so the selector samples sel and data in
// the same cycle the requester presents them.
// ---------------------------------------------------------------------------
module elixirchip_es1_spu_op_sel_arbiter #(
    parameter int unsigned N             = 4,
    parameter int unsigned SEL_BITS      = $clog2(N),
    parameter int unsigned LATENCY       = 1,
    parameter bit          CLEAR_ON_IDLE = 1'b1,
    parameter string       DEVICE        = "RTL",
    parameter string       SIMULATION    = "false",
    parameter string       DEBUG         = "false"
) (
    input  logic reset,
    input  logic clk,
    input  logic cke,
    elixirchip_es1_spu_op_sel_arbiter_if.slave bus
);

    logic [SEL_BITS-1:0] ptr;
    logic                lock;
    logic [SEL_BITS-1:0] lock_id;

    logic                grant_found;
    logic [SEL_BITS-1:0] grant_idx;
    logic [SEL_BITS-1:0] cand;

    // Grant search: locked owner only, else first requester after ptr.
    always_comb begin : grant_search
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (lock) begin
            grant_found = bus.s_req[lock_id];
            grant_idx   = lock_id;
        end else begin
            for (int unsigned k = 1; k <= N; k++) begin
                cand = SEL_BITS'((32'(ptr) + k) % N);
                if (!grant_found && bus.s_req[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    // Selector control; forced idle while reset is asserted.
    always_comb begin : grant_outputs
        bus.m_ack   = '0;
        bus.m_sel   = '0;
        bus.m_valid = 1'b0;
        if (!reset && grant_found) begin
            bus.m_ack   = N'(1) << grant_idx;
            bus.m_sel   = grant_idx;
            bus.m_valid = 1'b1;
        end
        bus.m_clear = CLEAR_ON_IDLE & ~bus.m_valid;
    end

    assign bus.m_busy = lock;

    // Pointer and burst lock update on a consumed beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= SEL_BITS'(N - 1);
            lock    <= 1'b0;
            lock_id <= '0;
        end else if (cke && grant_found) begin
            ptr <= grant_idx;
            if (bus.s_last[grant_idx]) begin
                lock <= 1'b0;
            end else begin
                lock    <= 1'b1;
                lock_id <= grant_idx;
            end
        end
    end

    // Beat-ownership tag, delayed to match the selector's data latency.
    if (LATENCY == 0) begin : g_tag_comb
        assign bus.out_valid = bus.m_valid;
        assign bus.out_id    = bus.m_sel;
    end else begin : g_tag_pipe
        localparam int unsigned ID_W = LATENCY * SEL_BITS;

        logic [LATENCY-1:0] valid_pipe;
        logic [ID_W-1:0]    id_pipe;

        // Stage 0 sits in the low bits; shifting left walks toward the output.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_pipe <= '0;
                id_pipe    <= '0;
            end else if (cke) begin
                valid_pipe <= LATENCY'({valid_pipe, bus.m_valid});
                id_pipe    <= ID_W'({id_pipe, bus.m_sel});
            end
        end

        assign bus.out_valid = valid_pipe[LATENCY-1];
        assign bus.out_id    = id_pipe[ID_W-1 -: SEL_BITS];
    end

    // Grant sanity check, kept out of real-device builds.
    localparam bit CHECKS_ON = (SIMULATION == "true") || (DEBUG == "true") ||
                               (DEVICE == "RTL");
    if (CHECKS_ON) begin : g_checks
        always_ff @(posedge clk) begin
            if (!reset) begin
                assert ($onehot0(bus.m_ack) && (bus.m_valid == (|bus.m_ack)));
            end
        end
    end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_sel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_elixirchip_es1_spu_op_sel_arbiter
// Three arbiters (LATENCY 0, 1, 3) share the same stimulus. A behavioural
// model (rotating priority search plus a history queue of consumed-edge
// selector inputs) is compared against every DUT on each falling edge;
// directed sequences also check hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_elixirchip_es1_spu_op_sel_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned SB = 2;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         cke    = 1'b1;
    logic [N-1:0] s_req  = '0;
    logic [N-1:0] s_last = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_sel_arbiter_if #(.N(N), .SEL_BITS(SB)) if0 ();
    elixirchip_es1_spu_op_sel_arbiter_if #(.N(N), .SEL_BITS(SB)) if1 ();
    elixirchip_es1_spu_op_sel_arbiter_if #(.N(N), .SEL_BITS(SB)) if3 ();

    assign if0.s_req = s_req;  assign if0.s_last = s_last;
    assign if1.s_req = s_req;  assign if1.s_last = s_last;
    assign if3.s_req = s_req;  assign if3.s_last = s_last;

    elixirchip_es1_spu_op_sel_arbiter #(.N(N), .SEL_BITS(SB), .LATENCY(0)) u_l0 (
        .reset(reset), .clk(clk), .cke(cke), .bus(if0)
    );
    elixirchip_es1_spu_op_sel_arbiter #(.N(N), .SEL_BITS(SB), .LATENCY(1)) u_l1 (
        .reset(reset), .clk(clk), .cke(cke), .bus(if1)
    );
    elixirchip_es1_spu_op_sel_arbiter #(.N(N), .SEL_BITS(SB), .LATENCY(3)) u_l3 (
        .reset(reset), .clk(clk), .cke(cke), .bus(if3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ptr     = N - 1;
    bit m_lock    = 1'b0;
    int m_lock_id = 0;
    bit hv[$];   // m_valid seen at each cke edge, newest first
    int hs[$];   // m_sel seen at each cke edge, newest first

    task automatic exp_out(input int lat, input bit ev, input int es,
                           output bit ov, output int oid);
        if (lat == 0) begin
            ov = ev; oid = es;
        end else if (hv.size() >= lat) begin
            ov = hv[lat-1]; oid = hs[lat-1];
        end else begin
            ov = 1'b0; oid = 0;
        end
    endtask

    task automatic check_dut(input string nm, input int lat,
                             input logic [N-1:0] ack, input logic [SB-1:0] sel,
                             input logic v, input logic c, input logic b,
                             input logic ov, input logic [SB-1:0] oid,
                             input bit ev, input int es, input int eb);
        bit e_ov;
        int e_oid;
        chk({nm, ".m_ack"},   32'(ack), ev ? (32'd1 << es) : 32'd0);
        chk({nm, ".m_sel"},   32'(sel), 32'(es));
        chk({nm, ".m_valid"}, 32'(v),   32'(ev));
        chk({nm, ".m_clear"}, 32'(c),   32'(!ev));
        if (!reset) chk({nm, ".m_busy"}, 32'(b), 32'(eb));
        if (!reset || lat == 0) begin
            exp_out(lat, ev, es, e_ov, e_oid);
            chk({nm, ".out_valid"}, 32'(ov), 32'(e_ov));
            chk({nm, ".out_id"},    32'(oid), 32'(e_oid));
        end
    endtask

    // Compare on the falling edge, then advance the model to the next rising edge.
    always @(negedge clk) begin
        bit f;
        int g;
        f = 1'b0;
        g = 0;
        if (!reset) begin
            if (m_lock) begin
                f = s_req[m_lock_id];
                g = m_lock_id;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (!f && s_req[(m_ptr + k) % N]) begin
                        f = 1'b1;
                        g = (m_ptr + k) % N;
                    end
                end
            end
        end
        if (!f) g = 0;

        check_dut("l0", 0, if0.m_ack, if0.m_sel, if0.m_valid, if0.m_clear, if0.m_busy,
                  if0.out_valid, if0.out_id, f, g, int'(m_lock));
        check_dut("l1", 1, if1.m_ack, if1.m_sel, if1.m_valid, if1.m_clear, if1.m_busy,
                  if1.out_valid, if1.out_id, f, g, int'(m_lock));
        check_dut("l3", 3, if3.m_ack, if3.m_sel, if3.m_valid, if3.m_clear, if3.m_busy,
                  if3.out_valid, if3.out_id, f, g, int'(m_lock));

        if (reset) begin
            m_ptr = N - 1; m_lock = 1'b0; m_lock_id = 0;
            hv.delete(); hs.delete();
        end else if (cke) begin
            hv.push_front(f); hs.push_front(g);
            if (hv.size() > 4) begin
                void'(hv.pop_back()); void'(hs.pop_back());
            end
            if (f) begin
                m_ptr = g;
                if (s_last[g]) m_lock = 1'b0;
                else begin m_lock = 1'b1; m_lock_id = g; end
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    // One cycle: change inputs just after the rising edge, settle before checks.
    task automatic cyc(input logic [N-1:0] rq, input logic [N-1:0] lt,
                       input logic ck, input logic rs);
        @(posedge clk);
        #1;
        s_req = rq; s_last = lt; cke = ck; reset = rs;
        #2;
    endtask

    int seq[5] = '{0, 1, 2, 3, 0};

    initial begin
        // reset state
        cyc(4'b0000, 4'b0000, 1'b1, 1'b1);
        chk("rst.m_valid", 32'(if1.m_valid), 32'd0);
        chk("rst.m_clear", 32'(if1.m_clear), 32'd1);
        chk("rst.m_ack",   32'(if1.m_ack),   32'd0);

        // all requesters, single beats: rotation 0,1,2,3,0
        cyc(4'b1111, 4'b1111, 1'b1, 1'b0);
        chk("rr0.m_sel",     32'(if1.m_sel),     32'd0);
        chk("rr0.m_ack",     32'(if1.m_ack),     32'b0001);
        chk("rr0.out_valid", 32'(if1.out_valid), 32'd0);
        for (int b = 1; b < 5; b++) begin
            cyc(4'b1111, 4'b1111, 1'b1, 1'b0);
            chk("rr.m_sel",     32'(if1.m_sel),     32'(seq[b]));
            chk("rr.m_ack",     32'(if1.m_ack),     32'd1 << seq[b]);
            chk("rr.l1_out_id", 32'(if1.out_id),    32'(seq[b-1]));
            chk("rr.l1_out_v",  32'(if1.out_valid), 32'd1);
            chk("rr.l0_out_id", 32'(if0.out_id),    32'(seq[b]));
        end

        // locked 4-beat burst on requester 2, others join after beat 1
        cyc(4'b0100, 4'b0000, 1'b1, 1'b0);
        chk("lk0.m_sel",  32'(if1.m_sel),  32'd2);
        chk("lk0.m_busy", 32'(if1.m_busy), 32'd0);
        cyc(4'b1111, 4'b0000, 1'b1, 1'b0);
        chk("lk1.m_sel",  32'(if1.m_sel),  32'd2);
        chk("lk1.m_busy", 32'(if1.m_busy), 32'd1);
        cyc(4'b1111, 4'b0000, 1'b1, 1'b0);
        chk("lk2.m_sel",  32'(if1.m_sel),  32'd2);
        chk("lk2.m_busy", 32'(if1.m_busy), 32'd1);
        cyc(4'b1111, 4'b0100, 1'b1, 1'b0);
        chk("lk3.m_sel",  32'(if1.m_sel),  32'd2);
        chk("lk3.m_busy", 32'(if1.m_busy), 32'd1);
        cyc(4'b1111, 4'b1111, 1'b1, 1'b0);
        chk("lk4.m_sel",  32'(if1.m_sel),  32'd3);
        chk("lk4.m_busy", 32'(if1.m_busy), 32'd0);

        // locked owner 1 drops its request for two cycles
        cyc(4'b0010, 4'b0000, 1'b1, 1'b0);
        chk("gap0.m_sel", 32'(if1.m_sel), 32'd1);
        for (int i = 0; i < 2; i++) begin
            cyc(4'b1101, 4'b0000, 1'b1, 1'b0);
            chk("gap.m_valid", 32'(if1.m_valid), 32'd0);
            chk("gap.m_clear", 32'(if1.m_clear), 32'd1);
            chk("gap.m_busy",  32'(if1.m_busy),  32'd1);
        end
        cyc(4'b1111, 4'b0010, 1'b1, 1'b0);
        chk("gap.resume", 32'(if1.m_sel), 32'd1);

        // clock enable low for three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, 4'b1111, 1'b0, 1'b0);
            chk("cke.m_sel",  32'(if1.m_sel),     32'd2);
            chk("cke.out_id", 32'(if1.out_id),    32'd1);
            chk("cke.out_v",  32'(if1.out_valid), 32'd1);
        end
        cyc(4'b1111, 4'b1111, 1'b1, 1'b0);
        chk("cke1.m_sel",  32'(if1.m_sel),  32'd2);
        chk("cke1.out_id", 32'(if1.out_id), 32'd1);
        cyc(4'b1111, 4'b1111, 1'b1, 1'b0);
        chk("cke2.m_sel",  32'(if1.m_sel),  32'd3);
        chk("cke2.out_id", 32'(if1.out_id), 32'd2);

        // reset in the middle of a burst on requester 3
        cyc(4'b1000, 4'b0000, 1'b1, 1'b0);
        chk("mrs0.m_sel", 32'(if1.m_sel), 32'd3);
        cyc(4'b1000, 4'b0000, 1'b1, 1'b0);
        chk("mrs1.m_busy", 32'(if1.m_busy), 32'd1);
        cyc(4'b1001, 4'b0000, 1'b1, 1'b1);
        chk("mrs.rst_valid", 32'(if1.m_valid), 32'd0);
        cyc(4'b1001, 4'b1111, 1'b1, 1'b0);
        chk("mrs.m_sel",  32'(if1.m_sel),     32'd0);
        chk("mrs.m_busy", 32'(if1.m_busy),    32'd0);
        chk("mrs.l1_ov",  32'(if1.out_valid), 32'd0);
        chk("mrs.l3_ov",  32'(if3.out_valid), 32'd0);
        cyc(4'b0000, 4'b1111, 1'b1, 1'b0);
        chk("mrs.l1_ov2", 32'(if1.out_valid), 32'd1);
        chk("mrs.l1_id2", 32'(if1.out_id),    32'd0);
        chk("mrs.idle_v", 32'(if1.m_valid),   32'd0);

        // random requests, bursts, clock enable and occasional reset
        for (int i = 0; i < 400; i++) begin
            cyc(N'($urandom), N'($urandom) | N'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
        end
        cyc(4'b0000, 4'b1111, 1'b1, 1'b0);
        repeat (4) cyc(4'b0000, 4'b1111, 1'b1, 1'b0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
